// File: rtl/ysyx_24120013_pkg.sv
// Shared types and constants for the ysyx_24120013 instruction fetch unit.
package ysyx_24120013_pkg;

    localparam int unsigned IFU_ADDR_W       = 32;
    localparam int unsigned IFU_DATA_W       = 32;
    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } ifu_state_t;

endpackage

// File: rtl/ysyx_24120013_ifu.sv
// Instruction fetch unit: owns the PC, one outstanding imem read, valid/ready to the IDU.
// Optional IFU_ALIGN_CHECK_EN: misaligned redirect targets trap into a sticky FAULT state.
module ysyx_24120013_ifu
    import ysyx_24120013_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = IFU_ADDR_W,
    parameter int unsigned           DATA_WIDTH = IFU_DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] IFU_inst,
    output logic [ADDR_WIDTH-1:0] IFU_pc,
    output logic                  IFU_valid,
    input  logic                  IDU_ready,
    output logic                  IFU_fault
);

    ifu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic                  req_q;
    logic                  drop_q, drop_d;
    logic [ADDR_WIDTH-1:0] redir_pc_c;

`ifdef IFU_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic redir_bad_c;

    assign redir_pc_c  = redirect_pc;
    assign redir_bad_c = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign IFU_fault   = fault_q;
`else
    // Without the checker, targets are silently word-aligned.
    assign redir_pc_c  = redirect_pc & ~ADDR_WIDTH'(INST_BYTES - 1);
    assign IFU_fault   = 1'b0;
`endif

    // Next-state, PC and hold-register update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
`ifdef IFU_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid) pc_d = redir_pc_c;
                if (imem_gnt) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d   = redir_pc_c;
                    drop_d = 1'b1;
                end
                if (imem_rvalid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // A redirect wins over a same-cycle handshake; the held word is wrong-path.
                if (redirect_valid) begin
                    pc_d    = redir_pc_c;
                    valid_d = 1'b0;
                    state_d = REQ;
                end else if (IDU_ready) begin
                    pc_d    = pc_q + ADDR_WIDTH'(INST_BYTES);
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            FAULT: state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase
`ifdef IFU_ALIGN_CHECK_EN
        if (redir_bad_c && (state_q != IDLE)) begin
            state_d = FAULT;
            pc_d    = pc_q;
            drop_d  = 1'b0;
            valid_d = 1'b0;
            fault_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            inst_q  <= DATA_WIDTH'(NOP_INST);
            ipc_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= pc_d;
            req_q   <= (state_d == REQ);
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fault_q <= 1'b0;
        else      fault_q <= fault_d;
    end
`endif

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign IFU_inst  = inst_q;
    assign IFU_pc    = ipc_q;
    assign IFU_valid = valid_q;

endmodule
